// File: rtl/regfile_dump_reader_if.sv
// Streaming output bundle of the register-file dump reader.
// Handshake: an entry moves when out_valid and out_ready are both 1 at a
// rising clk edge. The producer holds out_index/out_data stable while
// out_valid=1 and out_ready=0. out_valid never depends on out_ready.
interface regfile_dump_reader_if;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic [31:0] out_data;

    modport master (
        output out_valid,
        output out_index,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Sequential read-out engine for the 32 x 32-bit register file.
// Walks the read-address port from FIRST_REG to LAST_REG. Each step waits one
// cycle for the file's clocked read latency. Each (index, value) pair is then
// streamed out on the dump interface.
// Per entry, the FSM goes ISSUE -> CAPTURE -> PRESENT. Every output,
// including busy, comes straight from a flop.
module regfile_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [4:0]                   read_reg,
    input  logic [31:0]                  read_data,
    regfile_dump_reader_if.master        dump,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   state_dbg
);

    // A range outside 0..31, or one that runs backwards, cannot be dumped.
    generate
        if (FIRST_REG < 0 || LAST_REG > 31 || LAST_REG < FIRST_REG) begin : g_bad_range
            $error("regfile_dump_reader: FIRST_REG/LAST_REG must satisfy 0 <= FIRST_REG <= LAST_REG <= 31");
        end
    endgenerate

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  idx, idx_nxt;
    logic [4:0]  read_reg_q, read_reg_nxt;
    logic        valid_q, valid_nxt;
    logic [4:0]  index_q, index_nxt;
    logic [31:0] data_q, data_nxt;
    logic        busy_q, busy_nxt;
    logic        done_q, done_nxt;

    // Next-state and next-output decode. Every target defaults to holding
    // its value, and done defaults to 0.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        read_reg_nxt = read_reg_q;
        valid_nxt    = valid_q;
        index_nxt    = index_q;
        data_nxt     = data_q;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    idx_nxt      = FIRST_IDX;
                    read_reg_nxt = FIRST_IDX;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                // The register file samples read_reg at the end of this cycle.
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                data_nxt  = read_data;
                index_nxt = idx;
                valid_nxt = 1'b1;
                state_nxt = PRESENT;
            end
            PRESENT: begin
                if (dump.out_ready) begin
                    valid_nxt = 1'b0;
                    // Terminal compare rather than wrap, so LAST_REG=31 stops cleanly.
                    if (idx == LAST_IDX) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt      = idx + 5'd1;
                        read_reg_nxt = idx + 5'd1;
                        state_nxt    = ISSUE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers, with a synchronous reset that drops any partial dump.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 5'd0;
            read_reg_q <= 5'd0;
            valid_q    <= 1'b0;
            index_q    <= 5'd0;
            data_q     <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            read_reg_q <= read_reg_nxt;
            valid_q    <= valid_nxt;
            index_q    <= index_nxt;
            data_q     <= data_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
        end
    end

    assign read_reg       = read_reg_q;
    assign dump.out_valid = valid_q;
    assign dump.out_index = index_q;
    assign dump.out_data  = data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign state_dbg      = state;

endmodule
